// File: rtl/logic_reduce_unit.sv
// logic_reduce_unit: folds a framed stream of WIDTH-bit words into one result
// using a per-frame bitwise operator (AND, OR, XOR, NAND).
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   op                operator (00 AND, 01 OR, 10 XOR, 11 NAND), taken on first beat
//   in_data/in_valid/in_last/in_ready   word input stream with framing
//   out_data/out_count/out_overflow     folded result, word count, truncation flag
//   out_valid/out_ready                 result handshake
module logic_reduce_unit #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] out_data_d;
  logic [CW-1:0]    out_count_d;
  logic             out_overflow_d;
  logic             out_valid_d;

  logic             beat;
  logic [WIDTH-1:0] acc_new;
  logic [CW-1:0]    cnt_inc;

  // NAND folds as AND; the inversion is applied only when the result is presented.
  function automatic logic [WIDTH-1:0] fold(input logic [1:0] f_op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (f_op)
      OP_OR:   fold = a | b;
      OP_XOR:  fold = a ^ b;
      default: fold = a & b;
    endcase
  endfunction

  // Ready is a pure decode of state (forced low during reset), independent of out_ready.
  assign in_ready = !rst && (state_q != HOLD);
  assign beat     = in_valid && in_ready;
  assign acc_new  = fold(op_q, acc_q, in_data);
  assign cnt_inc  = cnt_q + CW'(1);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      op_q         <= OP_AND;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      op_q         <= op_d;
      out_data     <= out_data_d;
      out_count    <= out_count_d;
      out_overflow <= out_overflow_d;
      out_valid    <= out_valid_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    ovf_d          = ovf_q;
    op_d           = op_q;
    out_data_d     = out_data;
    out_count_d    = out_count;
    out_overflow_d = out_overflow;
    out_valid_d    = out_valid;

    case (state_q)
      IDLE: begin
        if (beat) begin
          op_d  = op;
          acc_d = in_data;
          cnt_d = CW'(1);
          ovf_d = 1'b0;
          if (in_last) begin
            state_d        = HOLD;
            out_valid_d    = 1'b1;
            out_data_d     = (op == OP_NAND) ? ~in_data : in_data;
            out_count_d    = CW'(1);
            out_overflow_d = 1'b0;
          end else begin
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (beat) begin
          acc_d = acc_new;
          cnt_d = cnt_inc;
          // A last word landing exactly on MAX_LEN is a complete frame, not an overflow.
          if (in_last || (cnt_inc == CW'(MAX_LEN))) begin
            state_d        = HOLD;
            ovf_d          = !in_last;
            out_valid_d    = 1'b1;
            out_data_d     = (op_q == OP_NAND) ? ~acc_new : acc_new;
            out_count_d    = cnt_inc;
            out_overflow_d = !in_last;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ovf_q ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        if (beat && in_last) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
